// File: rtl/fft64_pkg.sv
// rtl/fft64_pkg.sv - shared constants, bin type and bit-reversal helper for the 64-point FFT
package fft64_pkg;

    localparam int FFT_N     = 64;
    localparam int FFT_LOG2N = 6;
    localparam int FFT_DW    = 16;

    // One complex FFT bin, real part in the upper half when packed.
    typedef struct packed {
        logic signed [FFT_DW-1:0] re;
        logic signed [FFT_DW-1:0] im;
    } fft_bin_t;

    function automatic logic [FFT_LOG2N-1:0] bitrev6(input logic [FFT_LOG2N-1:0] a);
        return {a[0], a[1], a[2], a[3], a[4], a[5]};
    endfunction

endpackage

// File: rtl/fft64_bank_ram.sv
// rtl/fft64_bank_ram.sv - 64-entry bank, one synchronous write port, one combinational read port
//
// Ports:
//   clk_i    - write clock
//   we_i     - write enable
//   waddr_i  - write address
//   wdata_i  - write data
//   raddr_i  - read address
//   rdata_o  - read data, combinational from raddr_i
//
// Contents are deliberately not reset.
module fft64_bank_ram
    import fft64_pkg::*;
#(
    parameter int W = 2 * FFT_DW
) (
    input  logic                 clk_i,
    input  logic                 we_i,
    input  logic [FFT_LOG2N-1:0] waddr_i,
    input  logic [W-1:0]         wdata_i,
    input  logic [FFT_LOG2N-1:0] raddr_i,
    output logic [W-1:0]         rdata_o
);

    logic [W-1:0] mem_q [FFT_N];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fft64_reorder.sv
// rtl/fft64_reorder.sv - ping-pong reorder buffer turning bit-reversed FFT bins into natural order
//
// Ports:
//   CLK, RST              - clock, asynchronous active-high reset
//   in_valid/in_ready     - input handshake; in_re/in_im carry a bin in bit-reversed arrival order
//   out_valid/out_ready   - output handshake; out_re/out_im carry the bin numbered out_idx
//   out_sof               - marks the first bin of each output frame
//
// Build option FFT64_REORDER_FFTSHIFT_EN: read bins 32..63 then 0..31 (DC centred);
// out_idx still reports the true bin number.
module fft64_reorder
    import fft64_pkg::*;
#(
    parameter int DW = FFT_DW
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DW-1:0]        in_re,
    input  logic [DW-1:0]        in_im,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DW-1:0]        out_re,
    output logic [DW-1:0]        out_im,
    output logic [FFT_LOG2N-1:0] out_idx,
    output logic                 out_sof
);

    localparam logic [FFT_LOG2N-1:0] LAST = FFT_LOG2N'(FFT_N - 1);

    logic [1:0]           full_q,  full_d;
    logic                 wbank_q, wbank_d;
    logic                 rbank_q, rbank_d;
    logic [FFT_LOG2N-1:0] wcnt_q,  wcnt_d;
    logic [FFT_LOG2N-1:0] rcnt_q,  rcnt_d;
    logic                 ov_q,    ov_d;
    logic [DW-1:0]        ore_q,   ore_d;
    logic [DW-1:0]        oim_q,   oim_d;
    logic [FFT_LOG2N-1:0] oidx_q,  oidx_d;
    logic                 osof_q,  osof_d;

    logic                 wr_fire;
    logic                 rd_load;
    logic [FFT_LOG2N-1:0] waddr;
    logic [FFT_LOG2N-1:0] raddr;
    logic [2*DW-1:0]      wdata;
    logic [2*DW-1:0]      rdata0, rdata1, rdata;

    assign in_ready = !full_q[wbank_q];
    assign wr_fire  = in_valid && in_ready;
    // Load the output register when the read bank holds a frame and the
    // register is empty or its current bin leaves this cycle.
    assign rd_load  = full_q[rbank_q] && (!ov_q || out_ready);

    assign waddr = bitrev6(wcnt_q);
    assign wdata = {in_re, in_im};

`ifdef FFT64_REORDER_FFTSHIFT_EN
    assign raddr = rcnt_q ^ 6'd32;
`else
    assign raddr = rcnt_q;
`endif

    fft64_bank_ram #(.W(2*DW)) u_bank0 (
        .clk_i   (CLK),
        .we_i    (wr_fire && !wbank_q),
        .waddr_i (waddr),
        .wdata_i (wdata),
        .raddr_i (raddr),
        .rdata_o (rdata0)
    );

    fft64_bank_ram #(.W(2*DW)) u_bank1 (
        .clk_i   (CLK),
        .we_i    (wr_fire && wbank_q),
        .waddr_i (waddr),
        .wdata_i (wdata),
        .raddr_i (raddr),
        .rdata_o (rdata1)
    );

    assign rdata = rbank_q ? rdata1 : rdata0;

    always_comb begin
        full_d  = full_q;
        wbank_d = wbank_q;
        rbank_d = rbank_q;
        wcnt_d  = wcnt_q;
        rcnt_d  = rcnt_q;
        ov_d    = ov_q;
        ore_d   = ore_q;
        oim_d   = oim_q;
        oidx_d  = oidx_q;
        osof_d  = osof_q;

        if (wr_fire) begin
            wcnt_d = wcnt_q + 1'b1;
            if (wcnt_q == LAST) begin
                full_d[wbank_q] = 1'b1;
                wbank_d         = !wbank_q;
            end
        end

        // The writer only ever sets a non-full bank and the reader only
        // clears a full one, so the two updates never touch the same flag.
        if (rd_load) begin
            ov_d   = 1'b1;
            ore_d  = rdata[2*DW-1:DW];
            oim_d  = rdata[DW-1:0];
            oidx_d = raddr;
            osof_d = (rcnt_q == '0);
            rcnt_d = rcnt_q + 1'b1;
            if (rcnt_q == LAST) begin
                full_d[rbank_q] = 1'b0;
                rbank_d         = !rbank_q;
            end
        end else if (out_ready) begin
            ov_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            full_q  <= '0;
            wbank_q <= 1'b0;
            rbank_q <= 1'b0;
            wcnt_q  <= '0;
            rcnt_q  <= '0;
            ov_q    <= 1'b0;
            ore_q   <= '0;
            oim_q   <= '0;
            oidx_q  <= '0;
            osof_q  <= 1'b0;
        end else begin
            full_q  <= full_d;
            wbank_q <= wbank_d;
            rbank_q <= rbank_d;
            wcnt_q  <= wcnt_d;
            rcnt_q  <= rcnt_d;
            ov_q    <= ov_d;
            ore_q   <= ore_d;
            oim_q   <= oim_d;
            oidx_q  <= oidx_d;
            osof_q  <= osof_d;
        end
    end

    assign out_valid = ov_q;
    assign out_re    = ore_q;
    assign out_im    = oim_q;
    assign out_idx   = oidx_q;
    assign out_sof   = osof_q;

endmodule

// File: tb/tb_fft64_reorder.sv
// tb/tb_fft64_reorder.sv - directed self-checking bench for fft64_reorder
module tb_fft64_reorder;

`ifdef FFT64_REORDER_FFTSHIFT_EN
    localparam int SHIFT = 32;
`else
    localparam int SHIFT = 0;
`endif

    logic        CLK = 1'b0;
    logic        RST;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_re, in_im;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_re, out_im;
    logic [5:0]  out_idx;
    logic        out_sof;

    fft64_reorder dut (
        .CLK       (CLK),
        .RST       (RST),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_re     (in_re),
        .in_im     (in_im),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_re    (out_re),
        .out_im    (out_im),
        .out_idx   (out_idx),
        .out_sof   (out_sof)
    );

    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_fail = 0;
    int n_acc  = 0;
    int n_wait = 0;

    int cap_re[$], cap_im[$], cap_idx[$], cap_sof[$];

    typedef struct {
        int k;
        int idx;
        int re;
        int sof;
    } vec_t;
    vec_t tbl[5];

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int brev(input int a);
        int r = 0;
        for (int i = 0; i < 6; i++)
            if (((a >> i) & 1) != 0) r |= (1 << (5 - i));
        return r;
    endfunction

    // Output monitor: samples 1 time unit before each rising edge.
    logic       prev_stall = 1'b0;
    logic [38:0] prev_word = '0;
    always begin
        @(negedge CLK);
        #4;
        if (RST) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_hold_valid", longint'(out_valid), 1);
                chk("stall_hold_data", longint'({out_re, out_im, out_idx, out_sof}), longint'(prev_word));
            end
            if (out_valid && out_ready) begin
                cap_re.push_back(int'(out_re));
                cap_im.push_back(int'(out_im));
                cap_idx.push_back(int'(out_idx));
                cap_sof.push_back(int'(out_sof));
            end
            prev_stall = out_valid && !out_ready;
            prev_word  = {out_re, out_im, out_idx, out_sof};
        end
    end

    task automatic clear_caps();
        cap_re.delete();
        cap_im.delete();
        cap_idx.delete();
        cap_sof.delete();
    endtask

    // Called on a falling edge; returns on the falling edge after the bin is accepted.
    task automatic send_bin(input int re, input int im);
        int t = 0;
        in_valid = 1'b1;
        in_re    = 16'(re);
        in_im    = 16'(im);
        #1;
        while (!in_ready && t < 3000) begin
            @(negedge CLK);
            #1;
            t++;
            n_wait++;
        end
        if (!in_ready) chk("in_ready_timeout", longint'(in_ready), 1);
        else n_acc++;
        @(negedge CLK);
    endtask

    function automatic int stim_re(input int kind, input int f, input int p);
        if (kind == 0) return f * 64 + p;
        return (p == 1) ? 100 : 0;
    endfunction

    function automatic int stim_im(input int kind, input int f, input int p);
        if (kind == 0) return 16'h4000 + f * 64 + p;
        return 0;
    endfunction

    task automatic send_frame(input int kind, input int f);
        for (int p = 0; p < 64; p++) send_bin(stim_re(kind, f, p), stim_im(kind, f, p));
    endtask

    task automatic wait_caps(input int n, input int budget);
        int t = 0;
        while (cap_re.size() < n && t < budget) begin
            @(negedge CLK);
            t++;
        end
        if (cap_re.size() < n) chk("output_count_timeout", cap_re.size(), n);
    endtask

    // Bin arriving at position p lands at address brev(p); so bin idx carries arrival brev(idx).
    task automatic check_frame(input int base, input int kind, input int f);
        int idx;
        if (cap_re.size() < base + 64) begin
            chk("frame_present", cap_re.size(), base + 64);
            return;
        end
        for (int k = 0; k < 64; k++) begin
            idx = k ^ SHIFT;
            chk("out_idx", cap_idx[base+k], idx);
            chk("out_re", cap_re[base+k], stim_re(kind, f, brev(idx)));
            chk("out_im", cap_im[base+k], stim_im(kind, f, brev(idx)));
            chk("out_sof", cap_sof[base+k], (k == 0) ? 1 : 0);
        end
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc0;

`ifdef FFT64_REORDER_FFTSHIFT_EN
        tbl[0] = '{k: 0,  idx: 32, re: 1,  sof: 1};
        tbl[1] = '{k: 1,  idx: 33, re: 33, sof: 0};
        tbl[2] = '{k: 2,  idx: 34, re: 17, sof: 0};
        tbl[3] = '{k: 32, idx: 0,  re: 0,  sof: 0};
        tbl[4] = '{k: 63, idx: 31, re: 62, sof: 0};
`else
        tbl[0] = '{k: 0,  idx: 0,  re: 0,  sof: 1};
        tbl[1] = '{k: 1,  idx: 1,  re: 32, sof: 0};
        tbl[2] = '{k: 2,  idx: 2,  re: 16, sof: 0};
        tbl[3] = '{k: 5,  idx: 5,  re: 40, sof: 0};
        tbl[4] = '{k: 63, idx: 63, re: 63, sof: 0};
`endif

        RST       = 1'b1;
        in_valid  = 1'b0;
        in_re     = '0;
        in_im     = '0;
        out_ready = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        chk("reset_in_ready", longint'(in_ready), 1);
        chk("reset_out_valid", longint'(out_valid), 0);
        chk("reset_out_re", longint'(out_re), 0);
        chk("reset_out_im", longint'(out_im), 0);
        chk("reset_out_idx", longint'(out_idx), 0);
        chk("reset_out_sof", longint'(out_sof), 0);
        @(negedge CLK);

        // Basic ramp frame followed back-to-back by an impulse frame.
        clear_caps();
        n_wait = 0;
        send_frame(0, 0);
        send_frame(1, 0);
        in_valid = 1'b0;
        chk("continuous_no_stall", n_wait, 0);
        wait_caps(128, 400);
        for (int i = 0; i < 5; i++) begin
            if (cap_re.size() > tbl[i].k) begin
                chk("tbl_idx", cap_idx[tbl[i].k], tbl[i].idx);
                chk("tbl_re", cap_re[tbl[i].k], tbl[i].re);
                chk("tbl_sof", cap_sof[tbl[i].k], tbl[i].sof);
            end
        end
        check_frame(0, 0, 0);
        check_frame(64, 1, 0);

        // Backpressure: three frames with the output stalled.
        repeat (5) @(negedge CLK);
        clear_caps();
        out_ready = 1'b0;
        acc0 = n_acc;
        fork
            begin
                send_frame(0, 1);
                send_frame(0, 2);
                send_frame(0, 3);
                in_valid = 1'b0;
            end
            begin
                repeat (200) @(negedge CLK);
                #1;
                chk("bp_accepted", n_acc - acc0, 128);
                chk("bp_in_ready_low", longint'(in_ready), 0);
                chk("bp_out_valid", longint'(out_valid), 1);
                out_ready = 1'b1;
            end
        join
        wait_caps(192, 600);
        repeat (20) @(negedge CLK);
        chk("bp_total_outputs", cap_re.size(), 192);
        check_frame(0, 0, 1);
        check_frame(64, 0, 2);
        check_frame(128, 0, 3);

        // Output ready toggling every cycle.
        clear_caps();
        fork
            begin
                send_frame(0, 4);
                send_frame(0, 5);
                in_valid = 1'b0;
            end
            begin
                repeat (300) begin
                    @(negedge CLK);
                    out_ready = ~out_ready;
                end
                out_ready = 1'b1;
            end
        join
        wait_caps(128, 600);
        repeat (20) @(negedge CLK);
        chk("toggle_total_outputs", cap_re.size(), 128);
        check_frame(0, 0, 4);
        check_frame(64, 0, 5);

        // Reset after 20 bins of a frame, then a fresh frame.
        clear_caps();
        for (int p = 0; p < 20; p++) send_bin(stim_re(0, 7, p), stim_im(0, 7, p));
        in_valid = 1'b0;
        #2;
        RST = 1'b1;
        #1;
        chk("midrst_in_ready", longint'(in_ready), 1);
        chk("midrst_out_valid", longint'(out_valid), 0);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        send_frame(0, 6);
        in_valid = 1'b0;
        #1;
        chk("latency_not_yet_valid", longint'(out_valid), 0);
        @(negedge CLK);
        #1;
        chk("latency_valid", longint'(out_valid), 1);
        chk("latency_first_idx", longint'(out_idx), SHIFT);
        chk("latency_first_sof", longint'(out_sof), 1);
        @(negedge CLK);
        wait_caps(64, 300);
        repeat (20) @(negedge CLK);
        chk("midrst_total_outputs", cap_re.size(), 64);
        check_frame(0, 0, 6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
